mult_seq: RTL and testbench
===========================

# mult_seq

Sequential N×N unsigned shift-and-add multiplier: accepts operands on a start request, forms the 2N-bit product one multiplier bit per clock in a double-wide product register, then flags completion. It sequences the Lab 1 product datapath: separate high/low half loads, add into the high half, and a right shift. It is the arithmetic unit that the lab's top level drives from switches/testbench.

## Interface
- N, default 8: operand width. Product is 2N bits. N ≥ 2.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high; priority over all other inputs.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  N  multiplicand, captured on the accepting edge.
- b  input  N  multiplier, captured on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse, high in DONE.
- product  output  2N  product register contents; final result valid from DONE until the next accepted start.

## Operation
- Reset: state IDLE, product = 0, multiplicand register = 0, bit counter = 0, busy = 0, done = 0.
- States: IDLE, RUN, DONE. busy and done are decoded from state only.
- IDLE: start = 1 at an edge → multiplicand ← a, product high half ← 0, product low half ← b, counter ← 0, go to RUN. start = 0 → hold; product retains its last value.
- RUN, every edge:
  - sum = {1'b0, hi} + (product[0] ? {1'b0, mcand} : 0), where sum is N+1 bits.
  - product ← {sum, lo} >> 1, i.e. the 2N+1-bit value shifted right by one and truncated to 2N.
  - counter ← counter + 1.
  - On the edge where counter == N−1, go to DONE.
- DONE: product held. The next edge always returns to IDLE.
- start outside IDLE, including in DONE, is ignored. a and b are don't-care outside the accepting edge.
- Reset mid-RUN or in DONE aborts: all state returns to reset values on that edge, and no done pulse is produced.
- Arithmetic: unsigned only. The carry out of the N-bit add is kept as bit N of sum and shifts into product[2N−1], so no overflow is possible. Counter width is $clog2(N).

## Timing
- Edge 0: start accepted; product = {0, b} after the edge.
- Edges 1..N: RUN iterations. busy is high from edge 0 to edge N.
- After edge N: DONE, done = 1 and product is final. After edge N+1: IDLE, done = 0.
- Latency from the accepting edge to done is N edges; done is high for exactly one cycle.
- With start held high: one result every N+2 cycles.
- The product register updates only on the accepting edge and on RUN edges.

## Structure
- Package mult_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t
  - localparam MULT_N_DEFAULT = 8
- Sub-module mult_fsm: holds the state register and bit counter.
  - Inputs: start, reset.
  - Outputs: load (accept edge), step (RUN edge), busy, done.
- mult_seq instantiates mult_fsm and contains the multiplicand register, the N+1-bit adder and the product register.

## Test plan
- Reset, then start with a=13, b=11 → busy for 8 cycles, done pulses after edge 8, product = 143 (0x008F), held afterwards.
- a=255, b=255 → product = 65025 (0xFE01), exercising the carry into the top bit.
- a=0, b=200 and a=200, b=0 → product = 0, with identical timing (done after edge 8).
- a=6, b=7 started; at edge 3 drive start=1 with a=9, b=9 → ignored, product = 42. A start during DONE is also ignored.
- Start a=100, b=3; assert reset at edge 4 → all outputs 0 after that edge and no done pulse. Then start a=5, b=5 → product = 25.
- start held high continuously with a=2, b=3 → done pulses every 10 cycles, product = 6 each time.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_N_DEFAULT = 8;

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between a multiplier client (master) and mult_seq (slave).
interface mult_seq_if
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_fsm.sv
// Sequencer for mult_seq: IDLE/RUN/DONE state and the iteration counter.
module mult_fsm
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic busy,
    output logic done
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: rtl/mult_seq.sv
// N x N unsigned shift-and-add multiplier, one multiplier bit per RUN cycle.
module mult_seq
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mult_seq_if.slave    bus
);
    logic           load;
    logic           step;
    logic           busy;
    logic           done;

    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [N:0]     sum;

    mult_fsm #(.N(N)) u_fsm (
        .clk   (clk),
        .reset (reset),
        .start (bus.start),
        .load  (load),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    // The adder carry is kept as sum[N] and lands in the top product bit after the shift.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        sum     = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (load) begin
            mcand_d = bus.a;
            prod_d  = {{N{1'b0}}, bus.b};
        end else if (step) begin
            prod_d  = {sum, prod_q[N-1:1]};
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = prod_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: timing, carry, ignored starts, reset abort, back-to-back runs.
module tb_mult_seq;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mult_seq_if #(.N(N)) bus ();

    mult_seq #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at edge 0, check busy through the run, done after edge N, idle after edge N+1.
    task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] exp);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        chk({tag, " load product"}, 32'(bus.product), 32'({8'h00, bv}));
        chk({tag, " busy e0"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i < N; i++) begin
            tick();
            chk({tag, " busy mid"}, 32'({bus.busy, bus.done}), 32'b10);
        end
        tick();
        chk({tag, " done"}, 32'({bus.busy, bus.done}), 32'b01);
        chk({tag, " product"}, 32'(bus.product), 32'(exp));
        tick();
        chk({tag, " idle"}, 32'({bus.busy, bus.done}), 32'b00);
        chk({tag, " held"}, 32'(bus.product), 32'(exp));
        $display("txn %s: a=%0d b=%0d product=%0d", tag, av, bv, bus.product);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("reset product", 32'(bus.product), 32'd0);
        chk("reset busy/done", 32'({bus.busy, bus.done}), 32'b00);
        reset = 1'b0;
        tick();

        run_mult("13x11", 8'd13, 8'd11, 16'h008F);
        tick();
        chk("13x11 still held", 32'(bus.product), 32'h008F);
        run_mult("255x255", 8'd255, 8'd255, 16'hFE01);
        run_mult("0x200", 8'd0, 8'd200, 16'd0);
        run_mult("200x0", 8'd200, 8'd0, 16'd0);

        // Starts during RUN and DONE must be ignored.
        bus.start = 1'b1;
        bus.a = 8'd6;
        bus.b = 8'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.a = 8'd9;
        bus.b = 8'd9;
        tick();
        bus.start = 1'b0;
        chk("ign run busy", 32'(bus.busy), 32'd1);
        for (int i = 4; i <= N; i++) tick();
        chk("ign done", 32'(bus.done), 32'd1);
        chk("ign product", 32'(bus.product), 32'd42);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign in done idle", 32'({bus.busy, bus.done}), 32'b00);
        chk("ign in done product", 32'(bus.product), 32'd42);
        tick();
        chk("ign stays idle", 32'({bus.busy, bus.done}), 32'b00);
        $display("txn ignore: a=6 b=7 product=%0d", bus.product);

        // Reset at edge 4 of a run aborts it.
        bus.start = 1'b1;
        bus.a = 8'd100;
        bus.b = 8'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort product", 32'(bus.product), 32'd0);
        chk("abort busy/done", 32'({bus.busy, bus.done}), 32'b00);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort no done", 32'({bus.busy, bus.done}), 32'b00);
        end
        $display("txn abort: a=100 b=3 product=%0d", bus.product);
        run_mult("5x5", 8'd5, 8'd5, 16'd25);

        // Start held high: accept every N+2 cycles.
        bus.start = 1'b1;
        bus.a = 8'd2;
        bus.b = 8'd3;
        tick();
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk("stream done", 32'(bus.done), ((i % 10) == 8) ? 32'd1 : 32'd0);
            if ((i % 10) == 8) begin
                chk("stream product", 32'(bus.product), 32'd6);
                $display("txn stream: cycle=%0d product=%0d", i, bus.product);
            end
        end
        bus.start = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
